// File: rtl/cpx_accum_dump_if.sv
// Stream bundle for the integrate-and-dump stage: the complex product stream
// coming in from the multiplier and the widened block sum going out.
interface cpx_accum_dump_if #(
  parameter int I_IN_BITS   = 24,
  parameter int Q_IN_BITS   = 24,
  parameter int LOG2_LENGTH = 4
);
  localparam int I_ACC_BITS = I_IN_BITS + LOG2_LENGTH;
  localparam int Q_ACC_BITS = Q_IN_BITS + LOG2_LENGTH;

  logic signed [I_IN_BITS-1:0]  i_in;
  logic signed [Q_IN_BITS-1:0]  q_in;
  logic                         valid_in;
  logic signed [I_ACC_BITS-1:0] i_out;
  logic signed [Q_ACC_BITS-1:0] q_out;
  logic                         valid_out;
  logic                         out_ready;

  // Driven by the producer of samples / consumer of sums.
  modport master (
    output i_in, q_in, valid_in, out_ready,
    input  i_out, q_out, valid_out
  );

  // Driven by the accumulator itself.
  modport slave (
    input  i_in, q_in, valid_in, out_ready,
    output i_out, q_out, valid_out
  );
endinterface

// File: rtl/cpx_accum_dump.sv
// Coherent integrate-and-dump of the complex product stream. Sums
// 2**LOG2_LENGTH accepted samples and presents one widened sum per block.
// The widening by LOG2_LENGTH bits makes overflow impossible, so there is no
// saturation logic.
module cpx_accum_dump #(
  parameter int I_IN_BITS   = 24,
  parameter int Q_IN_BITS   = 24,
  parameter int LOG2_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  cpx_accum_dump_if.slave        bus,
  output logic                   overrun,
  output logic [LOG2_LENGTH-1:0] count
);
  localparam int I_ACC_BITS = I_IN_BITS + LOG2_LENGTH;
  localparam int Q_ACC_BITS = Q_IN_BITS + LOG2_LENGTH;

  // The last sample of a block is the one that arrives while count is all ones.
  localparam logic [LOG2_LENGTH-1:0] CNT_LAST = '1;
  localparam logic [LOG2_LENGTH-1:0] CNT_ONE  = LOG2_LENGTH'(1);

  logic signed [I_ACC_BITS-1:0]  acc_i_q, acc_i_d;
  logic signed [Q_ACC_BITS-1:0]  acc_q_q, acc_q_d;
  logic [LOG2_LENGTH-1:0]        count_q, count_d;
  logic signed [I_ACC_BITS-1:0]  i_out_q, i_out_d;
  logic signed [Q_ACC_BITS-1:0]  q_out_q, q_out_d;
  logic                          valid_out_q, valid_out_d;
  logic                          overrun_q, overrun_d;

  logic signed [I_ACC_BITS-1:0]  i_ext;
  logic signed [Q_ACC_BITS-1:0]  q_ext;
  logic                          is_last;
  logic                          consumed;

  // Sign-extend the products to the accumulator width.
  assign i_ext = {{LOG2_LENGTH{bus.i_in[I_IN_BITS-1]}}, bus.i_in};
  assign q_ext = {{LOG2_LENGTH{bus.q_in[Q_IN_BITS-1]}}, bus.q_in};

  assign is_last  = (count_q == CNT_LAST);
  assign consumed = valid_out_q && bus.out_ready;

  // Next-state: clear beats everything; otherwise handshake then accumulate/dump.
  always_comb begin
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    count_d     = count_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    valid_out_d = valid_out_q;
    overrun_d   = overrun_q;

    if (clear) begin
      // Output registers keep their last sum; the incoming sample is dropped.
      acc_i_d     = '0;
      acc_q_d     = '0;
      count_d     = '0;
      valid_out_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      if (consumed) begin
        valid_out_d = 1'b0;
      end

      if (bus.valid_in) begin
        if (is_last) begin
          // Dump: the sum includes this cycle's sample, so bypass the accumulator.
          i_out_d     = acc_i_q + i_ext;
          q_out_d     = acc_q_q + q_ext;
          acc_i_d     = '0;
          acc_q_d     = '0;
          count_d     = '0;
          valid_out_d = 1'b1;
          // An unconsumed sum being replaced is the only way to lose data.
          if (valid_out_q && !bus.out_ready) begin
            overrun_d = 1'b1;
          end
        end else begin
          acc_i_d = acc_i_q + i_ext;
          acc_q_d = acc_q_q + q_ext;
          count_d = count_q + CNT_ONE;
        end
      end
    end
  end

  // State registers; reset drops any partial block immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      count_q     <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      valid_out_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      count_q     <= count_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      valid_out_q <= valid_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.i_out     = i_out_q;
  assign bus.q_out     = q_out_q;
  assign bus.valid_out = valid_out_q;
  assign overrun       = overrun_q;
  assign count         = count_q;
endmodule

// File: doc/cpx_accum_dump.md
Name: cpx_accum_dump

Overview:
- Integrate-and-dump stage directly downstream of cpx_multiply in the CAF datapath.
- Consumes the registered complex product stream (i_out/q_out of the multiplier).
- Coherently sums 2**LOG2_LENGTH accepted samples per block and presents one widened complex sum per block to the next stage (FFT / magnitude) over a valid/ready interface.

Parameters:
- I_IN_BITS, 24, signed width of in-phase input (matches multiplier i_out_bits).
- Q_IN_BITS, 24, signed width of quadrature input (matches multiplier q_out_bits).
- LOG2_LENGTH, 4, log2 of samples per dump; LENGTH = 2**LOG2_LENGTH; legal range 1..16.
- I_ACC_BITS, I_IN_BITS+LOG2_LENGTH, output width for I (derived; do not override).
- Q_ACC_BITS, Q_IN_BITS+LOG2_LENGTH, output width for Q (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous block restart.
- i_in  input  I_IN_BITS  signed product I.
- q_in  input  Q_IN_BITS  signed product Q.
- valid_in  input  1  i_in/q_in valid this cycle (no input backpressure; always accepted).
- i_out  output  I_ACC_BITS  signed block sum I.
- q_out  output  Q_ACC_BITS  signed block sum Q.
- valid_out  output  1  i_out/q_out hold an unconsumed sum.
- out_ready  input  1  downstream accepts sum when valid_out && out_ready.
- overrun  output  1  sticky: an unconsumed sum was overwritten.
- count  output  LOG2_LENGTH  samples accumulated in current block.

Behaviour:
- Reset (rst_n low, asynchronous): i_out=0, q_out=0, valid_out=0, overrun=0, count=0; internal accumulators=0. Release is synchronous to clk; first sample can be accepted on the first rising edge after release.
- Arithmetic:
  - Inputs are sign-extended to the accumulator width.
  - Accumulators are I_ACC_BITS/Q_ACC_BITS wide, two's complement, no saturation; overflow is impossible by construction.
- States: ACCUM is the only functional state; the count value defines the phase.
- On each edge with valid_in=1 and clear=0:
  - If count < LENGTH-1: acc_i += i_in, acc_q += q_in, count += 1.
  - If count == LENGTH-1 (dump): i_out <= acc_i + i_in, q_out <= acc_q + q_in, acc_i/acc_q <= 0, count <= 0 (wrap), valid_out <= 1.
- Latency: the sum appears on i_out/q_out with valid_out=1 one clock after the edge that accepted the LENGTH-th sample.
- valid_in=0: accumulators and count hold (gaps allowed anywhere in a block).
- Output handshake:
  - valid_out && out_ready at an edge with no dump: valid_out <= 0, and i_out/q_out hold their last value.
  - Dump at an edge where valid_out=1 and out_ready=1: new sum loads, valid_out stays 1, overrun unchanged.
  - Dump at an edge where valid_out=1 and out_ready=0: new sum overwrites, valid_out stays 1, overrun <= 1 (sticky).
- clear=1 (synchronous, highest priority after reset): acc_i/acc_q=0, count=0, valid_out=0, overrun=0. The same-cycle valid_in sample is discarded. i_out/q_out hold their value.
- Reset asserted mid-block: everything returns to reset values immediately and the partial sum is lost.
- LOG2_LENGTH=1: dump every 2nd accepted sample; same rules apply.

Test Plan:
- Reset then 16 consecutive samples i_in=1000, q_in=-500, out_ready=1 -> one cycle after the 16th edge: i_out=16000, q_out=-8000, valid_out high for exactly 1 cycle; count back to 0.
- Extreme values: 16 samples i_in=-2**23, q_in=2**23-1 -> i_out=-134217728, q_out=134217712; no wrap.
- Gaps: 16 samples of i=1, q=1 with valid_in toggling 1/0 -> single dump with i_out=16, q_out=16, occurring 1 cycle after the 16th valid sample; count holds during gaps.
- Backpressure: out_ready=0 across two blocks (i=1, then i=2) -> after block 2, i_out=32, valid_out=1, overrun=1. Raising out_ready for one cycle drops valid_out; overrun stays 1 until clear.
- clear at count=7 with valid_in=1 -> count=0, that sample discarded; next 16 samples of i=3 give i_out=48.
- rst_n pulsed low asynchronously (between edges) at count=10 with valid_out=1 -> all outputs 0 immediately; next full block of i=5 gives i_out=80.
